// File: rtl/id_shower_pkg.sv
// id_shower_pkg
//   Shared types and constants for the LED ID pattern shower.
//   - id_state_e : frame state (settling, valid, sequence done)
//   - rgb_t      : packed {r,g,b} colour, 8 bits per channel
//   - RGB_BLACK / RGB_WHITE colour constants
//   - num_frames(): number of bit frames for a given address width. It adds
//     the reference frame when ID_SHOWER_REF_FRAME_EN is defined.
package id_shower_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_VALID  = 2'd1,
        ST_DONE   = 2'd2
    } id_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK = 24'h000000;
    localparam rgb_t RGB_WHITE = 24'hFFFFFF;

    // Settle counter width; covers SETTLE_FRAMES up to 15.
    localparam int SETTLE_CNT_W = 4;

    function automatic int num_frames(input int addr_w);
`ifdef ID_SHOWER_REF_FRAME_EN
        return addr_w + 1;
`else
        return addr_w;
`endif
    endfunction

endpackage

// File: rtl/request_frame_tracker.sv
// request_frame_tracker
//   Watches the driver's request stream for strip frame starts and counts
//   them while the display is settling.
//   A frame start is a change of request away from address 0: the previous
//   request was 0 and the current one differs.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   clear            : hold the settle count at zero (not settling, or restart)
//   next_led_request : address of the LED the driver will send next
//   settled          : one-cycle pulse on the SETTLE_FRAMES-th frame start
module request_frame_tracker
    import id_shower_pkg::*;
#(
    parameter int ADDR_W        = 6,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [ADDR_W-1:0] next_led_request,
    output logic              settled
);

    localparam logic [SETTLE_CNT_W-1:0] LAST_CNT = SETTLE_CNT_W'(SETTLE_FRAMES - 1);

    logic [ADDR_W-1:0]       prev_req;
    logic [SETTLE_CNT_W-1:0] frame_cnt;
    logic                    frame_start;

    assign frame_start = (next_led_request != prev_req) && (prev_req == '0);
    assign settled     = frame_start && !clear && (frame_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_req  <= '0;
            frame_cnt <= '0;
        end else begin
            prev_req <= next_led_request;
            if (clear) begin
                frame_cnt <= '0;
            end else if (frame_start) begin
                // The count restarts once the settle target is reached.
                frame_cnt <= settled ? '0 : frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/id_pattern_shower.sv
// id_pattern_shower
//   Colours every LED by one selected bit of its own address, so a camera
//   can decode LED identities frame by frame. The index of the shown bit is
//   stepped by buttons (manual) or by capture_done pulses (auto sequence).
//   Optional build macro ID_SHOWER_REF_FRAME_EN adds a white reference frame
//   at index LED_ADDRESS_WIDTH.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   auto_mode             : level, 1 = automatic capture sequence
//   increment_bit         : manual step up, rising edge
//   decrement_bit         : manual step down, rising edge
//   next_led_request      : LED address the driver will send next
//   capture_done          : one-cycle pulse from the camera side
//   red/green/blue_out    : colour for the request seen one cycle earlier
//   color_valid           : colour outputs valid (1 whenever out of reset)
//   displayed_frame_valid : strip shows a settled frame for address_bit_num
//   address_bit_num       : current frame index
//   sequence_done         : automatic sequence finished (held)
//   state_dbg             : current frame state (id_state_e encoding)
//
// Camera handshake: displayed_frame_valid is the "ready" side and
// capture_done the "valid" side. A capture_done pulse is accepted only in a
// cycle where displayed_frame_valid is 1 and auto_mode is 1; a pulse in any
// other cycle is dropped. Acceptance lowers displayed_frame_valid on the next
// cycle, so each settled frame accepts exactly one capture.
module id_pattern_shower
    import id_shower_pkg::*;
#(
    parameter int          NUM_LEDS          = 50,
    parameter int          LED_ADDRESS_WIDTH = 6,
    parameter int          SETTLE_FRAMES     = 2,
    parameter int          MSB_FIRST         = 1,
    parameter logic [23:0] COLOR_ZERO        = 24'hFF0000,
    parameter logic [23:0] COLOR_ONE         = 24'h0000FF,
    localparam int         NUM_FRAMES        = num_frames(LED_ADDRESS_WIDTH),
    localparam int         BN_W              = $clog2(NUM_FRAMES + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         auto_mode,
    input  logic                         increment_bit,
    input  logic                         decrement_bit,
    input  logic [LED_ADDRESS_WIDTH-1:0] next_led_request,
    input  logic                         capture_done,
    output logic [7:0]                   red_out,
    output logic [7:0]                   green_out,
    output logic [7:0]                   blue_out,
    output logic                         color_valid,
    output logic                         displayed_frame_valid,
    output logic [BN_W-1:0]              address_bit_num,
    output logic                         sequence_done,
    output logic [1:0]                   state_dbg
);

    localparam int              W        = LED_ADDRESS_WIDTH;
    localparam logic [BN_W-1:0] LAST_IDX = BN_W'(NUM_FRAMES - 1);

    // A strip longer than the address space cannot be identified; this
    // block only exists as a marker in such a mis-configured build.
    if (NUM_LEDS > (1 << LED_ADDRESS_WIDTH)) begin : g_addr_too_narrow
    end

    id_state_e       state, state_nxt;
    logic [BN_W-1:0] idx, idx_nxt;
    logic            seq_done_nxt;
    logic            auto_q, inc_q, dec_q;
    logic            auto_rise, auto_fall, inc_edge, dec_edge;
    logic            restart;
    logic            settled;
    logic            tracker_clear;
    logic            addr_bit;
    rgb_t            color_nxt;

    assign auto_rise = auto_mode && !auto_q;
    assign auto_fall = !auto_mode && auto_q;
    assign inc_edge  = increment_bit && !inc_q;
    assign dec_edge  = decrement_bit && !dec_q;

    // The settle count only runs while settling, and a restart into SETTLE
    // always begins again from zero.
    assign tracker_clear = (state != ST_SETTLE) || restart;

    request_frame_tracker #(
        .ADDR_W       (W),
        .SETTLE_FRAMES(SETTLE_FRAMES)
    ) u_tracker (
        .clk             (clk),
        .rst             (rst),
        .clear           (tracker_clear),
        .next_led_request(next_led_request),
        .settled         (settled)
    );

    // Mode control and index stepping. Mode edges take priority over
    // everything; in auto mode the buttons are ignored, in manual mode
    // capture_done is ignored.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        seq_done_nxt = sequence_done;
        restart      = 1'b0;

        if (auto_rise) begin
            idx_nxt      = '0;
            seq_done_nxt = 1'b0;
            restart      = 1'b1;
        end else if (auto_fall) begin
            seq_done_nxt = 1'b0;
            restart      = 1'b1;
        end else if (auto_mode) begin
            if (state == ST_VALID && capture_done) begin
                if (idx == LAST_IDX) begin
                    state_nxt    = ST_DONE;
                    seq_done_nxt = 1'b1;
                end else begin
                    idx_nxt = idx + 1'b1;
                    restart = 1'b1;
                end
            end
        end else if (inc_edge && !dec_edge) begin
            idx_nxt = (idx == LAST_IDX) ? '0 : idx + 1'b1;
            restart = 1'b1;
        end else if (dec_edge && !inc_edge) begin
            idx_nxt = (idx == '0) ? LAST_IDX : idx - 1'b1;
            restart = 1'b1;
        end

        if (restart) begin
            state_nxt = ST_SETTLE;
        end else if (state == ST_SETTLE && settled) begin
            state_nxt = ST_VALID;
        end
    end

    // Colour for the current request, registered one cycle later.
    always_comb begin
        addr_bit = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (int'(idx) == ((MSB_FIRST != 0) ? (W - 1 - i) : i)) begin
                addr_bit = next_led_request[i];
            end
        end

        if (state == ST_DONE) begin
            color_nxt = RGB_BLACK;
`ifdef ID_SHOWER_REF_FRAME_EN
        end else if (int'(idx) == W) begin
            color_nxt = RGB_WHITE;
`endif
        end else begin
            color_nxt = addr_bit ? rgb_t'(COLOR_ONE) : rgb_t'(COLOR_ZERO);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_SETTLE;
            idx           <= '0;
            sequence_done <= 1'b0;
            red_out       <= 8'h00;
            green_out     <= 8'h00;
            blue_out      <= 8'h00;
            color_valid   <= 1'b0;
            // Load live levels so inputs held through reset do not fire.
            auto_q        <= auto_mode;
            inc_q         <= increment_bit;
            dec_q         <= decrement_bit;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            sequence_done <= seq_done_nxt;
            red_out       <= color_nxt.r;
            green_out     <= color_nxt.g;
            blue_out      <= color_nxt.b;
            color_valid   <= 1'b1;
            auto_q        <= auto_mode;
            inc_q         <= increment_bit;
            dec_q         <= decrement_bit;
        end
    end

    assign displayed_frame_valid = (state == ST_VALID);
    assign address_bit_num       = idx;
    assign state_dbg             = state;

endmodule
